east_output_port: RTL



---
 rtl/router_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 42 ++++
 rtl/east_output_port.sv | 62 ++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: packet field layout and hop-update helper shared by the router stages
// Fields: [15:8] payload, [7:4] dx (unsigned hops left), [3:0] dy
package router_pkg;
  localparam int PKT_W = 16;
  localparam int PL_MSB = 15;
  localparam int PL_LSB = 8;
  localparam int DX_MSB = 7;
  localparam int DX_LSB = 4;
  localparam int DY_MSB = 3;
  localparam int DY_LSB = 0;
  typedef struct packed {
    logic [PL_MSB-PL_LSB:0] payload;
    logic [DX_MSB-DX_LSB:0] dx;
    logic [DY_MSB-DY_LSB:0] dy;
  } packet_t;
  function automatic packet_t dec_dx(packet_t p);
    packet_t r;
    r = p;
    r.dx = (p.dx == '0) ? '0 : p.dx - 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO storage, no overflow handling
// Ports: clk, rst_n (async active-low); push/din write, pop reads; dout is the head entry;
//        full/empty/count report occupancy. Caller must not push when full without a pop,
//        nor pop when empty.
module sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_mem[r_wptr] <= din;
      if (push) r_wptr <= r_wptr + AW'(1);
      if (pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = r_mem[r_rptr];
  assign count = r_count;
  assign full  = r_count == CW'(DEPTH);
  assign empty = r_count == '0;
endmodule

// File: rtl/east_output_port.sv
// east_output_port: east egress stage - dx decrement, FWFT queue, drop-on-full with counter
// Ports: clk, rst_n (async active-low); packet_in/valid_in from forwarding stage;
//        packet_out/valid_out/ready_out toward east link; count/full/empty occupancy;
//        drop_cnt saturating drop count; dx_err sticky dx==0 arrival flag.
// Config: EAST_PORT_DROP_CNT_EN builds the drop counter; otherwise drop_cnt is tied to 0.
module east_output_port
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PKT_W-1:0]       packet_in,
  input  logic                   valid_in,
  output logic [PKT_W-1:0]       packet_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   dx_err
);
  packet_t w_in;
  logic    w_pop;
  logic    w_push;
  logic    r_dx_err;
  assign w_in      = packet_t'(packet_in);
  assign valid_out = !empty;
  assign w_pop     = valid_out && ready_out;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push    = valid_in && (!full || w_pop);
  sync_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (dec_dx(w_in)),
    .dout  (packet_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dx_err <= 1'b0;
    else if (valid_in && w_in.dx == '0) r_dx_err <= 1'b1;
  end
  assign dx_err = r_dx_err;
`ifdef EAST_PORT_DROP_CNT_EN
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_cnt;
  assign w_drop = valid_in && full && !w_pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
  end
  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif
endmodule
